// File: rtl/axi4_lite_mem_bridge.sv
// AXI4-Lite slave to synchronous memory bridge: decode window with DECERR, byte-enable
// pass-through, queued write responses and a single-outstanding read with fixed latency.
module axi4_lite_mem_bridge #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                MEM_AW    = 10,
  parameter int                RD_LAT    = 1,
  parameter int                BQ_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic                mem_wen,
  output logic [MEM_AW-1:0]   mem_waddr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wbe,
  output logic                mem_ren,
  output logic [MEM_AW-1:0]   mem_raddr,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int SB    = DATA_W / 8;
  localparam int AL    = $clog2(SB);
  localparam int BQ_AW = $clog2(BQ_DEPTH);
  localparam logic [BQ_AW:0] BQ_FULL = (BQ_AW + 1)'(BQ_DEPTH);

  function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:MEM_AW+AL] == BASE_ADDR[ADDR_W-1:MEM_AW+AL];
  endfunction

  function automatic logic [MEM_AW-1:0] addr_word(input logic [ADDR_W-1:0] a);
    return a[MEM_AW+AL-1:AL];
  endfunction

  // ---------------- write path ----------------
  logic              aw_full_reg, aw_full_next, w_full_reg, w_full_next;
  logic [ADDR_W-1:0] aw_addr_reg;
  logic [DATA_W-1:0] w_data_reg;
  logic [SB-1:0]     w_strb_reg;
  logic              awready_reg, wready_reg;
  logic              aw_hs, w_hs, aw_avail, w_avail, commit, wr_hit, b_pop;
  logic [ADDR_W-1:0] cur_awaddr;
  logic [DATA_W-1:0] cur_wdata;
  logic [SB-1:0]     cur_wstrb;

  logic [1:0]        bq_mem_reg [BQ_DEPTH];
  logic [BQ_AW-1:0]  bq_wr_ptr_reg, bq_rd_ptr_reg;
  logic [BQ_AW:0]    bq_count_reg;

  assign aw_hs      = s_awvalid & awready_reg;
  assign w_hs       = s_wvalid & wready_reg;
  assign aw_avail   = aw_full_reg | aw_hs;
  assign w_avail    = w_full_reg | w_hs;
  assign b_pop      = (bq_count_reg != '0) & s_bready;
  // A pop in the same cycle frees the slot the commit needs.
  assign commit     = aw_avail & w_avail & ((bq_count_reg != BQ_FULL) | b_pop);
  assign cur_awaddr = aw_full_reg ? aw_addr_reg : s_awaddr;
  assign cur_wdata  = w_full_reg ? w_data_reg : s_wdata;
  assign cur_wstrb  = w_full_reg ? w_strb_reg : s_wstrb;
  assign wr_hit     = addr_hit(cur_awaddr);

  assign aw_full_next = commit ? 1'b0 : (aw_full_reg | aw_hs);
  assign w_full_next  = commit ? 1'b0 : (w_full_reg | w_hs);

  assign mem_wen   = commit & wr_hit;
  assign mem_waddr = mem_wen ? addr_word(cur_awaddr) : '0;
  assign mem_wdata = mem_wen ? cur_wdata : '0;
  assign mem_wbe   = mem_wen ? cur_wstrb : '0;

  assign s_awready = awready_reg;
  assign s_wready  = wready_reg;
  assign s_bvalid  = (bq_count_reg != '0);
  assign s_bresp   = bq_mem_reg[bq_rd_ptr_reg];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_full_reg <= 1'b0;
      w_full_reg  <= 1'b0;
      aw_addr_reg <= '0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
    end else begin
      aw_full_reg <= aw_full_next;
      w_full_reg  <= w_full_next;
      if (aw_hs) aw_addr_reg <= s_awaddr;
      if (w_hs) begin
        w_data_reg <= s_wdata;
        w_strb_reg <= s_wstrb;
      end
      awready_reg <= ~aw_full_next;
      wready_reg  <= ~w_full_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BQ_DEPTH; i++) bq_mem_reg[i] <= 2'b00;
      bq_wr_ptr_reg <= '0;
      bq_rd_ptr_reg <= '0;
      bq_count_reg  <= '0;
    end else begin
      if (commit) begin
        bq_mem_reg[bq_wr_ptr_reg] <= wr_hit ? 2'b00 : 2'b11;
        bq_wr_ptr_reg             <= bq_wr_ptr_reg + 1'b1;
      end
      if (b_pop) bq_rd_ptr_reg <= bq_rd_ptr_reg + 1'b1;
      if (commit && !b_pop)      bq_count_reg <= bq_count_reg + 1'b1;
      else if (!commit && b_pop) bq_count_reg <= bq_count_reg - 1'b1;
    end
  end

  // ---------------- read path ----------------
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;

  rstate_t           state_reg, state_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic              rd_hit_reg, rd_hit_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic [1:0]        rresp_reg, rresp_next;
  logic              rvalid_reg, rvalid_next;
  logic              arready_reg, ar_hs;

  assign ar_hs     = s_arvalid & arready_reg;
  assign s_arready = arready_reg;
  assign s_rdata   = rdata_reg;
  assign s_rresp   = rresp_reg;
  assign s_rvalid  = rvalid_reg;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    rd_hit_next = rd_hit_reg;
    rdata_next  = rdata_reg;
    rresp_next  = rresp_reg;
    rvalid_next = rvalid_reg;
    mem_ren     = 1'b0;
    mem_raddr   = '0;
    case (state_reg)
      R_IDLE: begin
        if (ar_hs) begin
          rd_hit_next = addr_hit(s_araddr);
          mem_ren     = rd_hit_next;
          mem_raddr   = rd_hit_next ? addr_word(s_araddr) : '0;
          cnt_next    = 3'(RD_LAT);
          state_next  = R_WAIT;
        end
      end
      R_WAIT: begin
        // Count of 1 here is the cycle in which mem_rdata carries the requested word.
        cnt_next = cnt_reg - 3'd1;
        if (cnt_reg == 3'd1) begin
          rdata_next  = rd_hit_reg ? mem_rdata : '0;
          rresp_next  = rd_hit_reg ? 2'b00 : 2'b11;
          rvalid_next = 1'b1;
          state_next  = R_RESP;
        end
      end
      R_RESP: begin
        if (s_rready) begin
          rvalid_next = 1'b0;
          state_next  = R_IDLE;
        end
      end
      default: state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= R_IDLE;
      cnt_reg     <= '0;
      rd_hit_reg  <= 1'b0;
      rdata_reg   <= '0;
      rresp_reg   <= 2'b00;
      rvalid_reg  <= 1'b0;
      arready_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      rd_hit_reg  <= rd_hit_next;
      rdata_reg   <= rdata_next;
      rresp_reg   <= rresp_next;
      rvalid_reg  <= rvalid_next;
      arready_reg <= (state_next == R_IDLE);
    end
  end

endmodule

// File: tb/tb_axi4_lite_mem_bridge.sv
// Directed bench for axi4_lite_mem_bridge with a 2-cycle-latency byte-writable memory model.
module tb_axi4_lite_mem_bridge;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MEM_AW = 10;
  localparam int RD_LAT = 2;
  localparam int BQ_DEPTH = 4;
  localparam logic [31:0] BASE = 32'h0000_4000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] s_awaddr = '0;
  logic              s_awvalid = 1'b0;
  logic              s_awready;
  logic [DATA_W-1:0] s_wdata = '0;
  logic [3:0]        s_wstrb = '0;
  logic              s_wvalid = 1'b0;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready = 1'b0;
  logic [ADDR_W-1:0] s_araddr = '0;
  logic              s_arvalid = 1'b0;
  logic              s_arready;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready = 1'b0;
  logic              mem_wen;
  logic [MEM_AW-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wbe;
  logic              mem_ren;
  logic [MEM_AW-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  axi4_lite_mem_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW), .RD_LAT(RD_LAT),
    .BQ_DEPTH(BQ_DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wbe(mem_wbe),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: byte-masked write, two-stage read pipeline (data valid 2 cycles after ren).
  logic [31:0] mem_arr [1024];
  logic [31:0] rd_pipe1, rd_pipe2;
  assign mem_rdata = rd_pipe2;

  initial begin
    for (int i = 0; i < 1024; i++) mem_arr[i] = 32'h0;
    mem_arr[0] = 32'hCAFE_F00D;
    rd_pipe1 = 32'h0;
    rd_pipe2 = 32'h0;
  end

  always @(posedge clk) begin
    if (mem_wen)
      for (int b = 0; b < 4; b++)
        if (mem_wbe[b]) mem_arr[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    rd_pipe1 <= mem_arr[mem_raddr];
    rd_pipe2 <= rd_pipe1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if ({s_awready, s_wready, s_arready} !== 3'b000) begin errors++;
      $display("FAIL rst_readies got %b exp 000", {s_awready, s_wready, s_arready}); end
    checks++; if ({s_bvalid, s_rvalid, mem_wen, mem_ren} !== 4'b0000) begin errors++;
      $display("FAIL rst_valids got %b exp 0000", {s_bvalid, s_rvalid, mem_wen, mem_ren}); end
    checks++; if ({s_rdata, s_rresp, s_bresp} !== 36'h0) begin errors++;
      $display("FAIL rst_data got %h exp 0", {s_rdata, s_rresp, s_bresp}); end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({s_awready, s_wready, s_arready} !== 3'b000) begin errors++;
      $display("FAIL rel_readies_pre got %b exp 000", {s_awready, s_wready, s_arready}); end
    step();
    @(negedge clk);
    checks++; if ({s_awready, s_wready, s_arready} !== 3'b111) begin errors++;
      $display("FAIL rel_readies got %b exp 111", {s_awready, s_wready, s_arready}); end
    step();
  endtask

  task automatic test_write_same_cycle();
    s_awaddr = 32'h4010; s_awvalid = 1'b1;
    s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF; s_wvalid = 1'b1;
    @(negedge clk);
    checks++; if (mem_wen !== 1'b1) begin errors++;
      $display("FAIL wr_same_wen got %b exp 1", mem_wen); end
    checks++; if ({mem_waddr, mem_wbe, mem_wdata} !== {10'd4, 4'hF, 32'hDEAD_BEEF}) begin errors++;
      $display("FAIL wr_same_bus got %h/%h/%h exp 004/f/deadbeef", mem_waddr, mem_wbe, mem_wdata); end
    checks++; if (s_bvalid !== 1'b0) begin errors++;
      $display("FAIL wr_same_bvalid_early got %b exp 0", s_bvalid); end
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
    @(negedge clk);
    checks++; if ({s_bvalid, s_bresp, mem_wen} !== 4'b1000) begin errors++;
      $display("FAIL wr_same_b got bvalid %b bresp %b wen %b exp 1 00 0", s_bvalid, s_bresp, mem_wen); end
    step();
    s_bready = 1'b0;
    @(negedge clk);
    checks++; if (s_bvalid !== 1'b0) begin errors++;
      $display("FAIL wr_same_bpop got %b exp 0", s_bvalid); end
    step();
  endtask

  task automatic test_w_before_aw();
    s_wdata = 32'h1122_3344; s_wstrb = 4'h3; s_wvalid = 1'b1;
    @(negedge clk);
    checks++; if (mem_wen !== 1'b0) begin errors++;
      $display("FAIL wfirst_wen_early got %b exp 0", mem_wen); end
    step();
    s_wvalid = 1'b0;
    @(negedge clk);
    checks++; if ({s_wready, s_awready} !== 2'b01) begin errors++;
      $display("FAIL wfirst_readies got %b exp 01", {s_wready, s_awready}); end
    step();
    step();
    s_awaddr = 32'h4008; s_awvalid = 1'b1;
    @(negedge clk);
    checks++; if ({mem_wen, mem_waddr, mem_wbe, mem_wdata} !== {1'b1, 10'd2, 4'h3, 32'h1122_3344}) begin errors++;
      $display("FAIL wfirst_commit got wen %b addr %h be %h data %h exp 1 002 3 11223344",
               mem_wen, mem_waddr, mem_wbe, mem_wdata); end
    step();
    s_awvalid = 1'b0; s_bready = 1'b1;
    @(negedge clk);
    checks++; if ({s_bvalid, s_bresp, s_wready} !== 4'b1001) begin errors++;
      $display("FAIL wfirst_b got bvalid %b bresp %b wready %b exp 1 00 1", s_bvalid, s_bresp, s_wready); end
    step();
    s_bready = 1'b0;
    @(negedge clk);
    checks++; if (s_bvalid !== 1'b0) begin errors++;
      $display("FAIL wfirst_single_b got %b exp 0", s_bvalid); end
    step();
  endtask

  task automatic test_bq_full();
    logic [31:0] addrs [5] = '{32'h4100, 32'h5000, 32'h4108, 32'h410C, 32'h4110};
    logic [1:0]  resps [5] = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b00};
    logic        wens  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    s_bready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_awaddr = addrs[i]; s_awvalid = 1'b1;
      s_wdata = 32'hA0 + i; s_wstrb = 4'hF; s_wvalid = 1'b1;
      @(negedge clk);
      checks++; if (mem_wen !== wens[i]) begin errors++;
        $display("FAIL bq_fill_wen%0d got %b exp %b", i, mem_wen, wens[i]); end
      step();
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge clk);
    checks++; if ({s_awready, s_wready, mem_wen, s_bvalid} !== 4'b0001) begin errors++;
      $display("FAIL bq_full_stall got aw %b w %b wen %b bvalid %b exp 0 0 0 1",
               s_awready, s_wready, mem_wen, s_bvalid); end
    step();
    s_bready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      checks++; if ({s_bvalid, s_bresp} !== {1'b1, resps[j]}) begin errors++;
        $display("FAIL bq_pop%0d got bvalid %b bresp %b exp 1 %b", j, s_bvalid, s_bresp, resps[j]); end
      if (j == 0) begin
        checks++; if ({mem_wen, mem_waddr, mem_wdata} !== {1'b1, 10'h44, 32'hA4}) begin errors++;
          $display("FAIL bq_late_commit got wen %b addr %h data %h exp 1 044 a4", mem_wen, mem_waddr, mem_wdata); end
      end
      step();
    end
    @(negedge clk);
    checks++; if ({s_bvalid, s_awready, s_wready} !== 3'b011) begin errors++;
      $display("FAIL bq_drained got bvalid %b aw %b w %b exp 0 1 1", s_bvalid, s_awready, s_wready); end
    s_bready = 1'b0;
    step();
  endtask

  task automatic test_read();
    s_araddr = 32'h4010; s_arvalid = 1'b1; s_rready = 1'b0;
    @(negedge clk);
    checks++; if ({mem_ren, mem_raddr, s_arready} !== {1'b1, 10'd4, 1'b1}) begin errors++;
      $display("FAIL rd_ren got ren %b addr %h arready %b exp 1 004 1", mem_ren, mem_raddr, s_arready); end
    step();
    s_arvalid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      checks++; if ({s_rvalid, s_arready, mem_ren} !== 3'b000) begin errors++;
        $display("FAIL rd_wait%0d got rvalid %b arready %b ren %b exp 0 0 0", c, s_rvalid, s_arready, mem_ren); end
      step();
    end
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      checks++; if ({s_rvalid, s_rresp, s_rdata, s_arready} !== {1'b1, 2'b00, 32'hDEAD_BEEF, 1'b0}) begin errors++;
        $display("FAIL rd_hold%0d got rvalid %b rresp %b rdata %h arready %b exp 1 00 deadbeef 0",
                 c, s_rvalid, s_rresp, s_rdata, s_arready); end
      step();
    end
    s_rready = 1'b1;
    @(negedge clk);
    checks++; if ({s_rvalid, s_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin errors++;
      $display("FAIL rd_hs got rvalid %b rdata %h exp 1 deadbeef", s_rvalid, s_rdata); end
    step();
    s_rready = 1'b0;
    @(negedge clk);
    checks++; if ({s_rvalid, s_arready} !== 2'b01) begin errors++;
      $display("FAIL rd_done got rvalid %b arready %b exp 0 1", s_rvalid, s_arready); end
    step();
    // Partial-strobe word written earlier: only the low two bytes landed.
    s_araddr = 32'h4008; s_arvalid = 1'b1; s_rready = 1'b1;
    step();
    s_arvalid = 1'b0;
    step();
    step();
    @(negedge clk);
    checks++; if ({s_rvalid, s_rresp, s_rdata} !== {1'b1, 2'b00, 32'h0000_3344}) begin errors++;
      $display("FAIL rd_bytes got rvalid %b rresp %b rdata %h exp 1 00 00003344", s_rvalid, s_rresp, s_rdata); end
    step();
    s_rready = 1'b0;
  endtask

  task automatic test_decerr();
    s_awaddr = 32'h5000; s_awvalid = 1'b1;
    s_wdata = 32'h55; s_wstrb = 4'hF; s_wvalid = 1'b1;
    @(negedge clk);
    checks++; if (mem_wen !== 1'b0) begin errors++;
      $display("FAIL dec_wen got %b exp 0", mem_wen); end
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
    @(negedge clk);
    checks++; if ({s_bvalid, s_bresp} !== 3'b111) begin errors++;
      $display("FAIL dec_bresp got bvalid %b bresp %b exp 1 11", s_bvalid, s_bresp); end
    step();
    s_bready = 1'b0;
    s_araddr = 32'h3FFC; s_arvalid = 1'b1; s_rready = 1'b1;
    @(negedge clk);
    checks++; if ({mem_ren, s_arready} !== 2'b01) begin errors++;
      $display("FAIL dec_ren got ren %b arready %b exp 0 1", mem_ren, s_arready); end
    step();
    s_arvalid = 1'b0;
    step();
    step();
    @(negedge clk);
    checks++; if ({s_rvalid, s_rresp, s_rdata} !== {1'b1, 2'b11, 32'h0}) begin errors++;
      $display("FAIL dec_rresp got rvalid %b rresp %b rdata %h exp 1 11 00000000", s_rvalid, s_rresp, s_rdata); end
    step();
    s_rready = 1'b0;
  endtask

  task automatic test_reset_midflight();
    s_bready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_awaddr = 32'h4200 + 4 * i; s_awvalid = 1'b1;
      s_wdata = 32'h77 + i; s_wstrb = 4'hF; s_wvalid = 1'b1;
      step();
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    s_araddr = 32'h4010; s_arvalid = 1'b1;
    @(negedge clk);
    checks++; if ({s_bvalid, mem_ren} !== 2'b11) begin errors++;
      $display("FAIL mid_setup got bvalid %b ren %b exp 1 1", s_bvalid, mem_ren); end
    step();
    s_arvalid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, mem_wen, mem_ren} !== 7'b0) begin errors++;
      $display("FAIL mid_rst got aw %b w %b ar %b bv %b rv %b wen %b ren %b exp all 0",
               s_awready, s_wready, s_arready, s_bvalid, s_rvalid, mem_wen, mem_ren); end
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    checks++; if ({s_awready, s_wready, s_arready} !== 3'b111) begin errors++;
      $display("FAIL mid_readies got %b exp 111", {s_awready, s_wready, s_arready}); end
    for (int c = 0; c < 4; c++) begin
      step();
      @(negedge clk);
      checks++; if ({s_bvalid, s_rvalid} !== 2'b00) begin errors++;
        $display("FAIL mid_stale%0d got bvalid %b rvalid %b exp 0 0", c, s_bvalid, s_rvalid); end
    end
    step();
  endtask

  initial begin
    #1 rst = 1'b1;
    test_reset();
    test_write_same_cycle();
    test_w_before_aw();
    test_bq_full();
    test_read();
    test_decerr();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
